// File: rtl/jump_loader_pkg.sv
// Shared types and defaults for the jump_loader input stage.
package jump_loader_pkg;

  localparam int unsigned NUM_JUMPS          = 5;
  localparam int unsigned DEFAULT_WIDTH      = 5;
  localparam int unsigned DEFAULT_DEB_CYCLES = 4;

  // load_idx doubles as the state encoding: next slot to write, 5 once full.
  typedef enum logic [2:0] {
    StEmpty = 3'd0,
    StFill1 = 3'd1,
    StFill2 = 3'd2,
    StFill3 = 3'd3,
    StFill4 = 3'd4,
    StReady = 3'd5
  } load_state_e;

endpackage

// File: rtl/debounce.sv
// 1-bit 2-FF synchronizer followed by a stable-count debouncer.
// The counter stage is built only when JUMP_LOADER_DEBOUNCE_EN is defined;
// otherwise the synchronizer output is passed straight through.
module debounce
  import jump_loader_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEFAULT_DEB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic deb
);

  logic sync1_q, sync2_q;

  // Two-flop synchronizer for the asynchronous input.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef JUMP_LOADER_DEBOUNCE_EN
  localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  // Counter value at which one more differing cycle completes the stable window.
  localparam logic [CntW-1:0] LastCnt = CntW'(DEB_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            deb_q, deb_d;

  // Count differing cycles; any agreeing cycle restarts the window.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync2_q != deb_q) begin
      if (cnt_q == LastCnt) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debouncer state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign deb = deb_q;
`else
  logic unused_deb_cycles;
  assign unused_deb_cycles = ^DEB_CYCLES;
  assign deb = sync2_q;
`endif

endmodule

// File: rtl/jump_loader.sv
// Input stage for the jump sequencer: conditions switches and buttons, then
// captures five jump values into slots on successive load presses.
// Debouncing is enabled by defining JUMP_LOADER_DEBOUNCE_EN.
module jump_loader
  import jump_loader_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned DEB_CYCLES = DEFAULT_DEB_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  input  logic             btn_clr,
  output logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] jump1,
  output logic [WIDTH-1:0] jump2,
  output logic [WIDTH-1:0] jump3,
  output logic [WIDTH-1:0] jump4,
  output logic [WIDTH-1:0] jump5,
  output logic             ok,
  output logic [2:0]       load_idx
);

  logic load_db, clr_db;
  logic load_db_q, clr_db_q;
  logic load_p, clr_p;

  load_state_e state_q, state_d;
  logic        wr_en, clr_all;
  logic [2:0]  wr_slot;
  logic        ok_q;

  logic [WIDTH-1:0] jump_q [NUM_JUMPS];

  for (genvar i = 0; i < WIDTH; i++) begin : g_sw_deb
    debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_sw_deb (
      .clk  (clk),
      .reset(reset),
      .raw  (sw[i]),
      .deb  (in[i])
    );
  end

  debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_load_deb (
    .clk  (clk),
    .reset(reset),
    .raw  (btn_load),
    .deb  (load_db)
  );

  debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_clr_deb (
    .clk  (clk),
    .reset(reset),
    .raw  (btn_clr),
    .deb  (clr_db)
  );

  // Delayed copies of the debounced buttons for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_db_q <= 1'b0;
      clr_db_q  <= 1'b0;
    end else begin
      load_db_q <= load_db;
      clr_db_q  <= clr_db;
    end
  end

  assign load_p = load_db & ~load_db_q;
  assign clr_p  = clr_db & ~clr_db_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: clear has priority over load; loads in READY are dropped.
  always_comb begin
    state_d = state_q;
    if (clr_p) begin
      state_d = StEmpty;
    end else if (load_p) begin
      unique case (state_q)
        StEmpty: state_d = StFill1;
        StFill1: state_d = StFill2;
        StFill2: state_d = StFill3;
        StFill3: state_d = StFill4;
        StFill4: state_d = StReady;
        StReady: state_d = StReady;
        default: state_d = StEmpty;
      endcase
    end
  end

  // Slot write strobes derived from the current state.
  always_comb begin
    clr_all = clr_p;
    wr_en   = load_p & ~clr_p & (state_q != StReady);
    wr_slot = state_q;
  end

  // Slot registers.
  always_ff @(posedge clk) begin
    if (reset || clr_all) begin
      for (int i = 0; i < NUM_JUMPS; i++) begin
        jump_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_JUMPS; i++) begin
        if (wr_en && (wr_slot == 3'(i))) begin
          jump_q[i] <= in;
        end
      end
    end
  end

  // Registered ok so it rises with the fifth slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      ok_q <= 1'b0;
    end else begin
      ok_q <= (state_d == StReady);
    end
  end

  assign jump1    = jump_q[0];
  assign jump2    = jump_q[1];
  assign jump3    = jump_q[2];
  assign jump4    = jump_q[3];
  assign jump5    = jump_q[4];
  assign ok       = ok_q;
  assign load_idx = state_q;

endmodule

// File: tb/tb_jump_loader.sv
// Self-checking bench for jump_loader with a slot/index reference model.
// Latencies follow JUMP_LOADER_DEBOUNCE_EN (7 edges with DEB_CYCLES=4, else 3).
module tb_jump_loader;

  localparam int W   = 5;
  localparam int DEB = 4;
`ifdef JUMP_LOADER_DEBOUNCE_EN
  localparam int LAT = DEB + 3;
`else
  localparam int LAT = 3;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sw;
  logic         btn_load, btn_clr;
  logic [W-1:0] in, jump1, jump2, jump3, jump4, jump5;
  logic         ok;
  logic [2:0]   load_idx;

  wire  [W-1:0] dj [5];
  assign dj[0] = jump1;
  assign dj[1] = jump2;
  assign dj[2] = jump3;
  assign dj[3] = jump4;
  assign dj[4] = jump5;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: five slots and a fill count.
  logic [W-1:0] m_jump [5];
  int           m_idx;

  jump_loader #(
    .WIDTH     (W),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sw      (sw),
    .btn_load(btn_load),
    .btn_clr (btn_clr),
    .in      (in),
    .jump1   (jump1),
    .jump2   (jump2),
    .jump3   (jump3),
    .jump4   (jump4),
    .jump5   (jump5),
    .ok      (ok),
    .load_idx(load_idx)
  );

  always #5 clk = ~clk;

  function automatic void m_load(input logic [W-1:0] v);
    if (m_idx < 5) begin
      m_jump[m_idx] = v;
      m_idx++;
    end
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 5; i++) m_jump[i] = '0;
    m_idx = 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic press(input logic ld, input logic cl, input int n);
    btn_load = ld;
    btn_clr  = cl;
    idle(n);
    btn_load = 1'b0;
    btn_clr  = 1'b0;
    idle(14);
  endtask

  task automatic set_sw(input logic [W-1:0] v);
    sw = v;
    idle(10);
  endtask

  task automatic test_reset();
    reset = 1'b1; sw = 5'b11111; btn_load = 1'b1; btn_clr = 1'b0;
    idle(5);
    n_tests++;
    if ({in, jump1, jump2, jump3, jump4, jump5, ok, load_idx} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: in=%b jumps=%b %b %b %b %b ok=%b idx=%0d, required all 0",
               in, jump1, jump2, jump3, jump4, jump5, ok, load_idx);
    end
    reset = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k == LAT - 2) begin
        n_tests++;
        if (in !== 5'b0) begin
          n_fail++; $display("FAIL reset_in_early: got %b required 00000", in);
        end
      end
      if (k == LAT - 1) begin
        n_tests++;
        if (in !== 5'b11111 || load_idx !== 3'd0) begin
          n_fail++;
          $display("FAIL reset_in_latency: in=%b idx=%0d required 11111 / 0", in, load_idx);
        end
      end
    end
    m_load(5'b11111);
    n_tests++;
    if (load_idx !== 3'd1 || jump1 !== 5'b11111 || ok !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_load: idx=%0d jump1=%b ok=%b required 1 / 11111 / 0",
               load_idx, jump1, ok);
    end
    btn_load = 1'b0;
    idle(14);
  endtask

  task automatic test_clear_latency();
    btn_clr = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k == LAT - 1) begin
        n_tests++;
        if (load_idx !== 3'd1 || jump1 !== 5'b11111) begin
          n_fail++;
          $display("FAIL clear_early: idx=%0d jump1=%b required 1 / 11111", load_idx, jump1);
        end
      end
    end
    m_clear();
    n_tests++;
    if (load_idx !== 3'd0 || jump1 !== 5'b0 || ok !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_latency: idx=%0d jump1=%b ok=%b required 0 / 00000 / 0",
               load_idx, jump1, ok);
    end
    btn_clr = 1'b0;
    idle(14);
  endtask

  task automatic test_glitch();
    set_sw(5'b10101);
    for (int i = 0; i < 6; i++) begin
      btn_load = (i % 2 == 0);
      tick();
    end
    btn_load = 1'b0;
    idle(14);
`ifndef JUMP_LOADER_DEBOUNCE_EN
    // Without debouncing each of the three high samples is a separate press.
    for (int i = 0; i < 3; i++) m_load(5'b10101);
`endif
    n_tests++;
    if (load_idx !== 3'(m_idx) || in !== 5'b10101) begin
      n_fail++;
      $display("FAIL glitch_idx_in: idx=%0d in=%b required %0d / 10101", load_idx, in, m_idx);
    end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (dj[i] !== m_jump[i]) begin
        n_fail++; $display("FAIL glitch_jump%0d: got %b required %b", i + 1, dj[i], m_jump[i]);
      end
    end
    press(1'b0, 1'b1, 10);
    m_clear();
    n_tests++;
    if (load_idx !== 3'd0) begin
      n_fail++; $display("FAIL glitch_clear: idx=%0d required 0", load_idx);
    end
  endtask

  task automatic test_fill();
    logic [W-1:0] vals [5];
    vals[0] = 5'b00001; vals[1] = 5'b10000; vals[2] = 5'b00010;
    vals[3] = 5'b00001; vals[4] = 5'b00001;
    for (int s = 0; s < 5; s++) begin
      set_sw(vals[s]);
      press(1'b1, 1'b0, 10);
      m_load(vals[s]);
      n_tests++;
      if (load_idx !== 3'(m_idx) || ok !== (m_idx == 5)) begin
        n_fail++;
        $display("FAIL fill_step%0d: idx=%0d ok=%b required %0d / %b",
                 s + 1, load_idx, ok, m_idx, m_idx == 5);
      end
    end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (dj[i] !== m_jump[i]) begin
        n_fail++; $display("FAIL fill_jump%0d: got %b required %b", i + 1, dj[i], m_jump[i]);
      end
    end
  endtask

  task automatic test_ready_ignore();
    set_sw(5'b01110);
    press(1'b1, 1'b0, 10);
    m_load(5'b01110);
    n_tests++;
    if (load_idx !== 3'd5 || ok !== 1'b1) begin
      n_fail++; $display("FAIL ready_state: idx=%0d ok=%b required 5 / 1", load_idx, ok);
    end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (dj[i] !== m_jump[i]) begin
        n_fail++; $display("FAIL ready_jump%0d: got %b required %b", i + 1, dj[i], m_jump[i]);
      end
    end
  endtask

  task automatic test_clear_wins();
    logic [W-1:0] v;
    press(1'b0, 1'b1, 10);
    m_clear();
    for (int s = 0; s < 2; s++) begin
      v = W'($urandom);
      set_sw(v);
      press(1'b1, 1'b0, 10);
      m_load(v);
    end
    n_tests++;
    if (load_idx !== 3'd2 || jump2 !== m_jump[1]) begin
      n_fail++;
      $display("FAIL both_setup: idx=%0d jump2=%b required 2 / %b", load_idx, jump2, m_jump[1]);
    end
    set_sw(W'($urandom));
    press(1'b1, 1'b1, 10);
    m_clear();
    n_tests++;
    if ({jump1, jump2, jump3, jump4, jump5, ok, load_idx} !== '0) begin
      n_fail++;
      $display("FAIL both_clear_wins: jumps=%b %b %b %b %b ok=%b idx=%0d required all 0",
               jump1, jump2, jump3, jump4, jump5, ok, load_idx);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] v;
    int           op;
    for (int it = 0; it < 20; it++) begin
      v  = W'($urandom);
      op = int'($urandom_range(0, 4));
      set_sw(v);
      case (op)
        0, 1, 2: begin press(1'b1, 1'b0, int'($urandom_range(8, 14))); m_load(v); end
        3:       begin press(1'b0, 1'b1, int'($urandom_range(8, 14))); m_clear(); end
        default: begin press(1'b1, 1'b1, int'($urandom_range(8, 14))); m_clear(); end
      endcase
      n_tests++;
      if (load_idx !== 3'(m_idx) || ok !== (m_idx == 5) || in !== v) begin
        n_fail++;
        $display("FAIL rand%0d_state: idx=%0d ok=%b in=%b required %0d / %b / %b",
                 it, load_idx, ok, in, m_idx, m_idx == 5, v);
      end
      for (int i = 0; i < 5; i++) begin
        if (dj[i] !== m_jump[i]) begin
          n_fail++;
          $display("FAIL rand%0d_jump%0d: got %b required %b", it, i + 1, dj[i], m_jump[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midfill();
    press(1'b0, 1'b1, 10);
    m_clear();
    set_sw(5'b10010);
    press(1'b1, 1'b0, 10);
    m_load(5'b10010);
    n_tests++;
    if (load_idx !== 3'd1 || jump1 !== 5'b10010) begin
      n_fail++;
      $display("FAIL midfill_setup: idx=%0d jump1=%b required 1 / 10010", load_idx, jump1);
    end
    reset = 1'b1;
    tick();
    m_clear();
    n_tests++;
    if ({in, jump1, jump2, jump3, jump4, jump5, ok, load_idx} !== '0) begin
      n_fail++;
      $display("FAIL midfill_reset: in=%b jump1=%b ok=%b idx=%0d required all 0",
               in, jump1, ok, load_idx);
    end
    reset = 1'b0;
    idle(14);
    n_tests++;
    if (load_idx !== 3'd0 || jump1 !== 5'b0 || in !== 5'b10010) begin
      n_fail++;
      $display("FAIL midfill_after: idx=%0d jump1=%b in=%b required 0 / 00000 / 10010",
               load_idx, jump1, in);
    end
  endtask

  initial begin
    m_clear();
    test_reset();
    test_clear_latency();
    test_glitch();
    test_fill();
    test_ready_ignore();
    test_clear_wins();
    test_random();
    test_reset_midfill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
